// File: rtl/chan_mux_scan.sv
// Registered N_CH x W channel selector: manual select or auto-scan with a dwell count; optional parity (CHAN_MUX_PARITY_EN).
// Latency: inputs sampled at a capturing edge appear on out_data right after that edge (one register stage).
// Backpressure: a held sample (out_valid=1, out_ready=0) freezes data, channel and scan state; nothing is dropped.
module chan_mux_scan #(
    parameter int N_CH  = 8,
    parameter int W     = 8,
    parameter int DWELL = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
`ifdef CHAN_MUX_PARITY_EN
    ,
    output logic              out_par
`endif
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  scan_ptr;
    logic [DW_W-1:0]   dwell_cnt;
    logic              mode_d;

    logic              slot, cap, entry;
    logic [SEL_W-1:0]  ptr_eff, cap_ch;
    logic [DW_W-1:0]   dwell_eff;
    logic [W-1:0]      cap_data;

    // Capture decision and the channel/data it would load; a fresh scan entry restarts counting at zero.
    always_comb begin
        slot      = (state_q == EMPTY) || out_ready;
        cap       = slot && en;
        entry     = mode && !mode_d;
        ptr_eff   = entry ? '0 : scan_ptr;
        dwell_eff = entry ? '0 : dwell_cnt;
        cap_ch    = mode ? ptr_eff : sel;
        cap_data  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cap_ch == SEL_W'(c)) cap_data = in_data[c*W +: W];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // FSM next state: capture fills, an idle slot drains, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (cap)       state_d = FULL;
        else if (slot) state_d = EMPTY;
    end

    // FSM outputs.
    always_comb begin
        out_valid = (state_q == FULL);
    end

    // Sample register: loads only on a capture, so it keeps its last value when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
        end else if (cap) begin
            out_data <= cap_data;
            out_ch   <= cap_ch;
        end
    end

`ifdef CHAN_MUX_PARITY_EN
    // Even parity travels with the captured sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   out_par <= 1'b0;
        else if (cap) out_par <= ^cap_data;
    end
`endif

    // Scan pointer and dwell counter advance only on scan-mode captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ptr  <= '0;
            dwell_cnt <= '0;
        end else if (cap && mode) begin
            if (dwell_eff == DW_W'(DWELL - 1)) begin
                dwell_cnt <= '0;
                scan_ptr  <= (ptr_eff == SEL_W'(N_CH - 1)) ? '0 : ptr_eff + 1'b1;
            end else begin
                dwell_cnt <= dwell_eff + 1'b1;
                scan_ptr  <= ptr_eff;
            end
        end
    end

    // Previous-cycle mode, used to detect entry into scan mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_d <= 1'b0;
        else        mode_d <= mode;
    end

endmodule

// File: tb/tb_chan_mux_scan.sv
// Bench for chan_mux_scan with N_CH=6 (non-power-of-two), W=8, DWELL=2.
// Directed phases then random traffic, all compared against a cycle-level reference model.
// Build with or without CHAN_MUX_PARITY_EN; parity is checked only when present.
module tb_chan_mux_scan;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int DW = 2;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [SW-1:0] sel = '0;
    logic          mode = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef CHAN_MUX_PARITY_EN
    logic          out_par;
`endif

    chan_mux_scan #(.N_CH(N), .W(W), .DWELL(DW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .mode      (mode),
        .en        (en),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CHAN_MUX_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] chan [N];

    // Reference model: what the output register should hold, plus scan position.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [SW-1:0] m_ch;
    logic         m_par;
    int           m_ptr, m_dwell;
    logic         m_prev_mode;

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_ch = '0; m_par = 0;
        m_ptr = 0; m_dwell = 0; m_prev_mode = 0;
    endtask

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_edge();
        int ch;
        if (!m_valid || out_ready) begin
            if (en) begin
                if (mode) begin
                    if (!m_prev_mode) begin m_ptr = 0; m_dwell = 0; end
                    ch = m_ptr;
                    m_dwell = m_dwell + 1;
                    if (m_dwell == DW) begin
                        m_dwell = 0;
                        m_ptr = (m_ptr + 1) % N;
                    end
                end else begin
                    ch = int'(sel);
                end
                m_data  = (ch < N) ? chan[ch] : '0;
                m_ch    = SW'(ch);
                m_par   = ^m_data;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        m_prev_mode = mode;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".data"},  32'(out_data),  32'(m_data));
        chk({tag, ".ch"},    32'(out_ch),    32'(m_ch));
`ifdef CHAN_MUX_PARITY_EN
        chk({tag, ".par"},   32'(out_par),   32'(m_par));
`endif
    endtask

    // Drive inputs, take one edge, update the model, check #1 after the edge.
    task automatic step(input logic [SW-1:0] s, input logic md, input logic e,
                        input logic rdy, input string tag);
        sel = s; mode = md; en = e; out_ready = rdy;
        for (int c = 0; c < N; c++) in_data[c*W +: W] = chan[c];
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic randomize_chan();
        for (int c = 0; c < N; c++) chan[c] = W'($urandom);
    endtask

    // Async reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic async_reset(input logic md);
        #3 rst_n = 1'b0;
        mode = md;
        #1;
        model_reset();
        chk_all("async_rst");
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic md;
        model_reset();
        for (int c = 0; c < N; c++) chan[c] = 8'hA0 + 8'(c);

        // Reset state, then en=0 keeps the output empty.
        #2;
        chk_all("reset");
        #5 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(3'd0, 1'b0, 1'b0, 1'b1, "idle_en0");

        // Manual select with recognisable channel data.
        step(3'd5, 1'b0, 1'b1, 1'b1, "manual5");
        chk("manual5.const_data", 32'(out_data), 32'h0000_00A5);
        chk("manual5.const_ch", 32'(out_ch), 32'd5);
        step(3'd2, 1'b0, 1'b1, 1'b1, "manual2");
        chk("manual2.const_data", 32'(out_data), 32'h0000_00A2);

        // Out-of-range selects return zero but report the requested index.
        step(3'd7, 1'b0, 1'b1, 1'b1, "oor7");
        chk("oor7.const_data", 32'(out_data), 32'd0);
        chk("oor7.const_ch", 32'(out_ch), 32'd7);
        step(3'd6, 1'b0, 1'b1, 1'b1, "oor6");

        // en=0 in a slot drains but keeps the last sample bits.
        step(3'd1, 1'b0, 1'b0, 1'b1, "drain");

        // Scan from reset with mode held high: 0,0,1,1,...,5,5,0,0.
        async_reset(1'b1);
        for (int i = 0; i < 2*N + 2; i++) begin
            step(3'd0, 1'b1, 1'b1, 1'b1, "scan");
            chk("scan.seq", 32'(out_ch), 32'((i / DW) % N));
        end

        // Backpressure: four stalled cycles with changing data must not move anything.
        for (int i = 0; i < 4; i++) begin
            randomize_chan();
            step(3'd0, 1'b1, 1'b1, 1'b0, "stall");
            chk("stall.frozen_ch", 32'(out_ch), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            randomize_chan();
            step(3'd0, 1'b1, 1'b1, 1'b1, "resume");
        end

        // Mode 1 -> 0 -> 1 restarts the scan at 0,0.
        step(3'd4, 1'b0, 1'b1, 1'b1, "to_manual");
        for (int i = 0; i < 4; i++) begin
            step(3'd0, 1'b1, 1'b1, 1'b1, "rescan");
            chk("rescan.seq", 32'(out_ch), 32'(i / DW));
        end

        // Parity on known values.
        chan[2] = 8'h07;
        step(3'd2, 1'b0, 1'b1, 1'b1, "par07");
`ifdef CHAN_MUX_PARITY_EN
        chk("par07.const", 32'(out_par), 32'd1);
`endif
        chan[2] = 8'h03;
        step(3'd2, 1'b0, 1'b1, 1'b1, "par03");
`ifdef CHAN_MUX_PARITY_EN
        chk("par03.const", 32'(out_par), 32'd0);
`endif

        // Random traffic with occasional mode flips and mid-run resets.
        md = 1'b1;
        for (int i = 0; i < 400; i++) begin
            randomize_chan();
            if ($urandom_range(0, 9) == 0) md = ~md;
            step(SW'($urandom), md, ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), "rand");
            if (i == 150 || i == 300) async_reset(md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
